// File: rtl/utils_pkg.sv
// Shared Ethernet-domain types and constants.
// Holds the OutFIFO status/command structs and pointer/length types, plus
// the transmit scheduler's FSM encoding, descriptor layout and default
// stall timeout.
package utils_pkg;

  localparam int OUTFIFO_KB_SIZE   = 4;
  localparam int PTR_W             = 16;
  localparam int SCHED_TIMEOUT_CYC = 65535;

  typedef logic [15:0]      udp_length_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic empty;
    logic full;
    logic done;
  } s_fifo_st_t;

  typedef struct packed {
    logic        start;
    udp_length_t length;
    logic        clear;
  } s_fifo_cmd_t;

  typedef enum logic [2:0] {
    IDLE, HDR, START, WAIT_DONE, RELEASE, ABORT
  } fsm_sched_t;

  typedef struct packed {
    udp_length_t len;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
  } s_tx_desc_t;

  // A descriptor is usable only if it carries payload and fits the OutFIFO.
  function automatic logic desc_len_ok(udp_length_t len, int max_bytes);
    return (len != '0) && (int'(len) <= max_bytes);
  endfunction

endpackage

// File: rtl/eth_fifo.sv
// Small synchronous FIFO used as the scheduler's descriptor queue.
// Ports: clk/rst_n (sync, active-low), clear_i drops all entries,
// push_i/data_i write (ignored when full), pop_i advances the head
// (ignored when empty), data_o shows the head entry, empty_o/full_o flags.
// SLOTS must be a power of 2 and at least 2.
module eth_fifo #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(SLOTS);

  logic [WIDTH-1:0] mem [SLOTS];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr, rd;
  logic        do_push, do_pop;

  assign empty_o = (wr == rd);
  assign full_o  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign data_o  = mem[rd[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (clear_i) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + (AW+1)'(1);
      if (do_pop)  rd <= rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// Packet transmit scheduler for the OutFIFO.
// Queues descriptors (len, dst ip/port), waits until the OutFIFO holds a
// whole packet, hands the UDP header downstream, holds fifo_cmd start/length
// until the FIFO reports done, then retires the descriptor.
// Ports: clk_eth/rst_eth (sync, active-low); desc_* push handshake with
// desc_rej_o reject pulse; flush_i abort; fifo_st_i / fifo_cmd_o OutFIFO
// status and command; udp_hdr_* header handshake; busy_o, err_o (sticky
// timeout), pkt_cnt_o (completed packets, wraps).
module pkt_tx_sched
  import utils_pkg::*;
#(
  parameter int DESC_SLOTS  = 4,
  parameter int FIFO_BYTES  = OUTFIFO_KB_SIZE*1024,
  parameter int TIMEOUT_CYC = SCHED_TIMEOUT_CYC
) (
  input  logic        clk_eth,
  input  logic        rst_eth,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  udp_length_t desc_len_i,
  input  logic [31:0] desc_dst_ip_i,
  input  logic [15:0] desc_dst_port_i,
  output logic        desc_rej_o,
  input  logic        flush_i,
  input  s_fifo_st_t  fifo_st_i,
  output s_fifo_cmd_t fifo_cmd_o,
  output logic        udp_hdr_valid_o,
  input  logic        udp_hdr_ready_i,
  output udp_length_t udp_hdr_len_o,
  output logic [31:0] udp_hdr_dst_ip_o,
  output logic [15:0] udp_hdr_dst_port_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] pkt_cnt_o
);

  fsm_sched_t  state;
  s_tx_desc_t  in_desc, head;
  logic        q_empty, q_full;
  logic        run;
  logic        accept, len_ok, push, pop;
  ptr_t        occ;
  logic [31:0] wait_cnt;
  logic        unused_st;

  assign unused_st = &{1'b0, fifo_st_i.empty, fifo_st_i.full};

  // run holds ready low while in reset and releases it one edge later.
  assign desc_ready_o = run && !q_full && !flush_i;
  assign accept       = desc_valid_i && desc_ready_o;
  assign len_ok       = desc_len_ok(desc_len_i, FIFO_BYTES);
  assign push         = accept && len_ok;
  assign pop          = !flush_i && (state == RELEASE || state == ABORT);
  assign busy_o       = (state != IDLE) || !q_empty;

  // Modulo subtraction in pointer width stays correct across wrap.
  assign occ = fifo_st_i.wr_ptr - fifo_st_i.rd_ptr;

  assign in_desc = '{len: desc_len_i, dst_ip: desc_dst_ip_i, dst_port: desc_dst_port_i};

  eth_fifo #(
    .SLOTS (DESC_SLOTS),
    .WIDTH ($bits(s_tx_desc_t))
  ) u_desc_q (
    .clk     (clk_eth),
    .rst_n   (rst_eth),
    .clear_i (flush_i),
    .push_i  (push),
    .data_i  (in_desc),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_ff @(posedge clk_eth) begin
    if (!rst_eth) begin
      state              <= IDLE;
      run                <= 1'b0;
      desc_rej_o         <= 1'b0;
      fifo_cmd_o         <= '0;
      udp_hdr_valid_o    <= 1'b0;
      udp_hdr_len_o      <= '0;
      udp_hdr_dst_ip_o   <= '0;
      udp_hdr_dst_port_o <= '0;
      err_o              <= 1'b0;
      pkt_cnt_o          <= '0;
      wait_cnt           <= '0;
    end else begin
      run              <= 1'b1;
      desc_rej_o       <= accept && !len_ok;
      fifo_cmd_o.clear <= 1'b0;
      if (flush_i) begin
        state            <= IDLE;
        udp_hdr_valid_o  <= 1'b0;
        fifo_cmd_o.start <= 1'b0;
        fifo_cmd_o.clear <= 1'b1;
        err_o            <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!q_empty && occ >= head.len) begin
            // Header and length are latched here and held through WAIT_DONE.
            state              <= HDR;
            udp_hdr_valid_o    <= 1'b1;
            udp_hdr_len_o      <= head.len;
            udp_hdr_dst_ip_o   <= head.dst_ip;
            udp_hdr_dst_port_o <= head.dst_port;
            fifo_cmd_o.length  <= head.len;
          end
          HDR: if (udp_hdr_ready_i) begin
            state            <= START;
            udp_hdr_valid_o  <= 1'b0;
            fifo_cmd_o.start <= 1'b1;
          end
          START: begin
            state    <= WAIT_DONE;
            wait_cnt <= '0;
          end
          WAIT_DONE: begin
            wait_cnt <= wait_cnt + 32'd1;
            // done wins over a timeout landing on the same cycle. The
            // timeout leaves after exactly TIMEOUT_CYC cycles in this state.
            if (fifo_st_i.done) begin
              state            <= RELEASE;
              fifo_cmd_o.start <= 1'b0;
              pkt_cnt_o        <= pkt_cnt_o + 32'd1;
            end else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
              state            <= ABORT;
              fifo_cmd_o.start <= 1'b0;
              fifo_cmd_o.clear <= 1'b1;
              err_o            <= 1'b1;
            end
          end
          RELEASE, ABORT: state <= IDLE;
          default:        state <= IDLE;
        endcase
      end
    end
  end

endmodule
